image_store: RTL

- Single-port-per-side 64x64 RGB888 image memory that acts as the responder for the image processor's pixel interface.
- The processor presents row/col and reads in_pix; it writes back with out_we/out_pix, in place.
- A host side streams the image in (load), releases the processor (run), then streams the result out (dump).
- The block sequences these phases, latches the processor's done flags and counts run cycles.

---
 rtl/image_store.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/image_store.sv
// 64x64 RGB888 image memory sequencing host load, in-place processor run and host dump.
// The processor side reads combinationally at {row,col}; all writes land on posedge clk.
module image_store #(
    parameter int DIM     = 64,
    parameter int TIMEOUT = 1000000,
    parameter int PIXW    = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [PIXW-1:0]          ld_data,
    output logic                     proc_run,
    input  logic [$clog2(DIM)-1:0]   row,
    input  logic [$clog2(DIM)-1:0]   col,
    output logic [PIXW-1:0]          in_pix,
    input  logic                     out_we,
    input  logic [PIXW-1:0]          out_pix,
    input  logic                     mirror_done,
    input  logic                     gray_done,
    input  logic                     filter_done,
    output logic                     dp_valid,
    input  logic                     dp_ready,
    output logic [PIXW-1:0]          dp_data,
    output logic                     dp_last,
    output logic [2:0]               phase,
    output logic [2:0]               flags,
    output logic [23:0]              run_cycles
);

    localparam int SW    = $clog2(DIM);
    localparam int AW    = 2 * SW;
    localparam int DEPTH = DIM * DIM;

    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [23:0]   RC_MAX    = '1;
    localparam logic [31:0]   TMO_LIMIT = 32'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DUMP = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t state, next_state;

    logic [PIXW-1:0] mem [DEPTH];
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   proc_addr;

    logic load_fire;
    logic dump_fire;
    logic run_enter;
    logic ptr_clear;
    logic timeout_hit;
    logic [23:0] rc_inc;

    assign proc_addr = {row, col};
    assign in_pix    = mem[proc_addr];
    assign dp_data   = mem[ptr];
    assign phase     = state;

    // The cycle that would make the count reach TIMEOUT is the last one allowed in RUN.
    assign timeout_hit = ({8'd0, run_cycles} + 32'd1) >= TMO_LIMIT;
    assign rc_inc      = (run_cycles == RC_MAX) ? run_cycles : run_cycles + 24'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        proc_run   = 1'b0;
        dp_valid   = 1'b0;
        dp_last    = 1'b0;
        load_fire  = 1'b0;
        dump_fire  = 1'b0;
        run_enter  = 1'b0;
        ptr_clear  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state = S_LOAD;
                    ptr_clear  = 1'b1;
                end
            end
            S_LOAD: begin
                ld_ready  = 1'b1;
                load_fire = ld_valid;
                if (ld_valid && ptr == LAST_ADDR) begin
                    next_state = S_RUN;
                    run_enter  = 1'b1;
                    ptr_clear  = 1'b1;
                end
            end
            S_RUN: begin
                proc_run = 1'b1;
                // Completion beats a simultaneous timeout.
                if (filter_done) begin
                    next_state = S_DUMP;
                    ptr_clear  = 1'b1;
                end else if (timeout_hit) begin
                    next_state = S_ERR;
                end
            end
            S_DUMP: begin
                dp_valid  = 1'b1;
                dp_last   = (ptr == LAST_ADDR);
                dump_fire = dp_ready;
                if (dp_ready && ptr == LAST_ADDR) begin
                    next_state = S_DONE;
                end
            end
            S_ERR: begin
                next_state = S_ERR;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= '0;
            flags      <= '0;
            run_cycles <= '0;
        end else begin
            if (ptr_clear) begin
                ptr <= '0;
            end else if (load_fire || dump_fire) begin
                ptr <= ptr + 1'b1;
            end

            if (run_enter) begin
                flags      <= '0;
                run_cycles <= '0;
            end else if (state == S_RUN) begin
                flags      <= flags | {filter_done, gray_done, mirror_done};
                run_cycles <= rc_inc;
            end
        end
    end

    // Image contents survive reset; only the phase owning the memory may write it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (load_fire) begin
                mem[ptr] <= ld_data;
            end else if (state == S_RUN && out_we) begin
                mem[proc_addr] <= out_pix;
            end
        end
    end

endmodule
